// File: rtl/multicycle_controller.sv
// Control unit for the multicycle MIPS CPU: a 12-state Moore FSM that sequences each
// instruction and drives the datapath strobes, plus the combinational ALU decoder.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       mem_to_reg,
    output logic       reg_dest,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ir_write,
    output logic       mem_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StAddiExec = 4'd9,
        StAddiWb   = 4'd10,
        StJump     = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;
    localparam logic [1:0] AluOpNone  = 2'b11;

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       funct_ok;

    always_comb begin
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                              funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = StFetch;
        mem_to_reg = 1'b0;
        reg_dest   = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 2'b00;
        alu_op     = AluOpAdd;
        illegal_op = 1'b0;
        state      = state_q;

        case (state_q)
            StFetch: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                state_d   = StDecode;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiExec;
                    OpJ:        state_d = StJump;
                    OpRtype: begin
                        if (funct_ok) begin
                            state_d = StExecute;
                        end else begin
                            illegal_op = 1'b1;
                        end
                    end
                    default:    illegal_op = 1'b1;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OpSw) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                i_or_d  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluOpSub;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
            StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
            end
            StJump: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            // Unreachable encodings drive every output, alu_control included, to zero.
            default: alu_op = AluOpNone;
        endcase

        if (!rst_n) begin
            mem_to_reg = 1'b0;
            reg_dest   = 1'b0;
            i_or_d     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            reg_write  = 1'b0;
            pc_src     = 2'b00;
            alu_op     = AluOpAdd;
            illegal_op = 1'b0;
            state      = StFetch;
        end
    end

    always_comb begin
        alu_control = 3'b010;
        case (alu_op)
            AluOpAdd: alu_control = 3'b010;
            AluOpSub: alu_control = 3'b110;
            AluOpFunct: begin
                case (funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            default:  alu_control = 3'b000;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle MIPS CPU. Takes the `opcode`/`funct` fields that the datapath extracts from its instruction register and drives every datapath control strobe, mux select and ALU operation code. A 12-state Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. A combinational ALU decoder maps the FSM's ALU op class plus `funct` to `alu_control`.

## Interface
Parameters:
- none; all encodings are fixed below.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `opcode`  in  6  `instr[31:26]` from the datapath.
- `funct`  in  6  `instr[5:0]` from the datapath.
- `mem_to_reg`  out  1  register write data source: 0 = ALU-out register, 1 = memory-data register.
- `reg_dest`  out  1  destination register: 0 = rt, 1 = rd.
- `i_or_d`  out  1  memory address source: 0 = PC, 1 = ALU-out.
- `alu_src_a`  out  1  ALU A operand: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `ir_write`  out  1  instruction register load enable.
- `mem_write`  out  1  memory write enable.
- `pc_write`  out  1  unconditional PC load enable.
- `branch`  out  1  PC load enable, qualified by ALU zero in the datapath.
- `reg_write`  out  1  register file write enable.
- `pc_src`  out  2  next PC: 00 = ALU result, 01 = ALU-out register, 10 = jump target.
- `alu_control`  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal_op`  out  1  one-cycle pulse in DECODE when the instruction is unsupported.
- `state`  out  4  current FSM state encoding (debug/verification).

## Operation
State encodings and the outputs asserted in each state. Any output not listed is 0. `alu_op` is the internal ALU op class: 00 = add, 01 = sub, 10 = decode `funct`.

- **FETCH (0):** `ir_write`=1, `pc_write`=1, `alu_src_b`=01, `alu_op`=00. Next state: DECODE.
- **DECODE (1):** `alu_src_b`=11, `alu_op`=00 (computes the branch target).
  - lw 100011 or sw 101011 → MEMADR.
  - R-type 000000 → EXECUTE.
  - beq 000100 → BRANCH.
  - addi 001000 → ADDIEXEC.
  - j 000010 → JUMP.
  - Anything else → FETCH with `illegal_op`=1.
  - R-type with unsupported `funct` → FETCH with `illegal_op`=1.
- **MEMADR (2):** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. lw → MEMREAD; sw → MEMWRITE.
- **MEMREAD (3):** `i_or_d`=1. Next: MEMWB.
- **MEMWB (4):** `reg_write`=1, `mem_to_reg`=1, `reg_dest`=0. Next: FETCH.
- **MEMWRITE (5):** `i_or_d`=1, `mem_write`=1. Next: FETCH.
- **EXECUTE (6):** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next: ALUWB.
- **ALUWB (7):** `reg_write`=1, `reg_dest`=1, `mem_to_reg`=0. Next: FETCH.
- **BRANCH (8):** `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `branch`=1, `pc_src`=01. Next: FETCH.
- **ADDIEXEC (9):** `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: ADDIWB.
- **ADDIWB (10):** `reg_write`=1, `reg_dest`=0, `mem_to_reg`=0. Next: FETCH.
- **JUMP (11):** `pc_write`=1, `pc_src`=10. Next: FETCH.
- **Encodings 12–15:** unreachable; if entered, outputs are all 0 and the next state is FETCH.

ALU decoder (combinational):
- `alu_op` 00 → 010; `alu_op` 01 → 110.
- `alu_op` 10, by `funct`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
- Any other `funct` → 010.

Sampling rule: `opcode` and `funct` are sampled only in DECODE, MEMADR and EXECUTE. They are stable there because `ir_write` is 0 outside FETCH.

## Timing
- All outputs are Moore from `state`, except:
  - `alu_control` also depends on `funct`.
  - `illegal_op` depends on `opcode`/`funct` while in DECODE.
- While `rst_n`=0, at the edge, the state loads FETCH.
- While `rst_n`=0, combinationally, `ir_write`, `pc_write`, `mem_write`, `reg_write`, `branch` and `illegal_op` are forced to 0. The other outputs show FETCH values: `alu_src_b`=01, `alu_control`=010, all remaining outputs 0.
- The first cycle after `rst_n` rises is a real FETCH.
- Reset asserted mid-instruction aborts it: the next cycle is FETCH, and no write strobe asserts while `rst_n`=0.
- Cycles per instruction, counted from FETCH to the next FETCH:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles from an arbitrary state (e.g. MEMREAD) → `state`=0 and all write enables 0 throughout; after release, `ir_write`=`pc_write`=1 for exactly one cycle.
- **lw** (`opcode`=100011) → states 0,1,2,3,4,0; `reg_write`=1 and `mem_to_reg`=1 only in state 4.
- **sw** (101011) → states 0,1,2,5,0; `mem_write`=1 only in state 5; `reg_write` never 1.
- **R-type sweep:** `opcode`=0 with `funct` 100000/100010/100100/100101/101010 → `alu_control` in EXECUTE is 010/110/000/001/111, respectively; ALUWB has `reg_dest`=1.
- **beq and j:** beq (000100) → BRANCH with `branch`=1, `pc_src`=01, `alu_control`=110; j (000010) → JUMP with `pc_write`=1, `pc_src`=10; each returns to FETCH after 3 cycles.
- **Illegal:** `opcode`=111111, and separately `opcode`=0 with `funct`=000111 → `illegal_op`=1 for one cycle in DECODE; next state is 0; no write strobe asserts.
